// File: rtl/wbq_pkg.sv
// Shared types for the register writeback queue: default widths and the queued entry layout.
package wbq_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] regNum;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-match search over the occupied slots of the writeback queue for one operand lookup.
module wbq_fwd_match
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  wbq_entry_t        entries [DEPTH],
  input  logic [PW-1:0]     rdPtr,
  input  logic [CW-1:0]     count,
  input  logic [ADDR_W-1:0] lookupReg,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overwrites an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PW'(i);
      if ((CW'(i) < count) && (entries[idx].regNum == lookupReg)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO feeding the register file write port from memory and ALU producers.
// Optional operand forwarding from pending entries is enabled by defining WBQ_FORWARD_EN.
module reg_writeback_queue #(
  parameter int DATA_W = wbq_pkg::DATA_W,
  parameter int ADDR_W = wbq_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_reg,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        writeReg,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        fwd_reg1,
  output logic                     fwd_hit1,
  output logic [DATA_W-1:0]        fwd_data1,
  input  logic [ADDR_W-1:0]        fwd_reg2,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  import wbq_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if ((DATA_W != wbq_pkg::DATA_W) || (ADDR_W != wbq_pkg::ADDR_W)) begin : gBadWidth
    $error("reg_writeback_queue: DATA_W/ADDR_W must match wbq_pkg entry layout");
  end
  if ((DEPTH < 2) || ((1 << PW) != DEPTH)) begin : gBadDepth
    $error("reg_writeback_queue: DEPTH must be a power of two >= 2");
  end

  wbq_entry_t    entries [DEPTH];
  wbq_entry_t    head;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] countQ;
  logic [CW-1:0] free;
  logic          memPush;
  logic          aluPush;
  logic          pop;

  // Readiness uses only the registered occupancy; the pop happening this edge is not credited.
  assign free      = CW'(DEPTH) - countQ;
  assign mem_ready = (free >= CW'(1));
  assign alu_ready = (free >= (CW'(1) + CW'(mem_valid)));
  assign memPush   = mem_valid && mem_ready;
  assign aluPush   = alu_valid && alu_ready;
  assign pop       = (countQ != '0);
  assign count     = countQ;

  assign head      = entries[rdPtr];
  assign regWrite  = pop;
  assign writeReg  = pop ? head.regNum : '0;
  assign writeData = pop ? head.data   : '0;

  // Mem entry is the older of a same-edge pair, so it takes the lower slot.
  always_ff @(posedge clk) begin
    if (memPush) begin
      entries[wrPtr] <= '{regNum: mem_reg, data: mem_data};
    end
    if (aluPush) begin
      entries[wrPtr + PW'(memPush)] <= '{regNum: alu_reg, data: alu_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else begin
      wrPtr  <= wrPtr + PW'(memPush) + PW'(aluPush);
      rdPtr  <= rdPtr + PW'(pop);
      countQ <= countQ + CW'(memPush) + CW'(aluPush) - CW'(pop);
    end
  end

`ifdef WBQ_FORWARD_EN
  wbq_fwd_match #(.DEPTH(DEPTH)) uFwd1 (
    .entries  (entries),
    .rdPtr    (rdPtr),
    .count    (countQ),
    .lookupReg(fwd_reg1),
    .hit      (fwd_hit1),
    .data     (fwd_data1)
  );

  wbq_fwd_match #(.DEPTH(DEPTH)) uFwd2 (
    .entries  (entries),
    .rdPtr    (rdPtr),
    .count    (countQ),
    .lookupReg(fwd_reg2),
    .hit      (fwd_hit2),
    .data     (fwd_data2)
  );
`else
  logic unusedFwdReg;
  assign unusedFwdReg = ^{fwd_reg1, fwd_reg2};
  assign fwd_hit1  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Randomized and directed checks of reg_writeback_queue against a queue-based reference model.
module tb_reg_writeback_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
`ifdef WBQ_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_valid = 1'b0, alu_valid = 1'b0;
  logic              mem_ready, alu_ready;
  logic [ADDR_W-1:0] mem_reg = '0, alu_reg = '0;
  logic [DATA_W-1:0] mem_data = '0, alu_data = '0;
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] fwd_reg1 = '0, fwd_reg2 = '0;
  logic              fwd_hit1, fwd_hit2;
  logic [DATA_W-1:0] fwd_data1, fwd_data2;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  reg_writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .fwd_reg1(fwd_reg1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_reg2(fwd_reg2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count)
  );

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t        pending[$];
  logic [31:0] modelRf [16];
  logic [31:0] obsRf   [16];
  int          errors = 0;
  int          checks = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {hit, data} of the youngest pending entry for register r.
  function automatic logic [32:0] fwdModel(input logic [ADDR_W-1:0] r);
    logic [32:0] res = '0;
    for (int i = pending.size() - 1; i >= 0; i--) begin
      if (pending[i].r == r) begin
        res = {1'b1, pending[i].d};
        break;
      end
    end
    return FWD_EN ? res : 33'd0;
  endfunction

  // Drive one cycle of inputs at the negedge, check outputs, then advance the model across the edge.
  task automatic step(input bit mv, input logic [3:0] mr, input logic [31:0] md,
                      input bit av, input logic [3:0] ar, input logic [31:0] ad,
                      input logic [3:0] f1, input logic [3:0] f2);
    bit          expMr, expAr;
    logic [3:0]  hr = '0;
    logic [31:0] hd = '0;
    logic [32:0] e1, e2;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    fwd_reg1 = f1; fwd_reg2 = f2;
    #1;
    expMr = pending.size() <= DEPTH - 1;
    expAr = (pending.size() + int'(mv)) <= DEPTH - 1;
    if (pending.size() != 0) begin
      hr = pending[0].r;
      hd = pending[0].d;
    end
    e1 = fwdModel(f1);
    e2 = fwdModel(f2);
    checkEq("mem_ready", 32'(mem_ready), 32'(expMr));
    checkEq("alu_ready", 32'(alu_ready), 32'(expAr));
    checkEq("count", 32'(count), pending.size());
    checkEq("regWrite", 32'(regWrite), 32'(pending.size() != 0));
    checkEq("writeReg", 32'(writeReg), 32'(hr));
    checkEq("writeData", writeData, hd);
    checkEq("fwd_hit1", 32'(fwd_hit1), 32'(e1[32]));
    checkEq("fwd_data1", fwd_data1, e1[31:0]);
    checkEq("fwd_hit2", 32'(fwd_hit2), 32'(e2[32]));
    checkEq("fwd_data2", fwd_data2, e2[31:0]);
    if (regWrite === 1'b1) obsRf[writeReg] = writeData;
    @(posedge clk);
    if (pending.size() != 0) begin
      modelRf[pending[0].r] = pending[0].d;
      void'(pending.pop_front());
    end
    if (mv && expMr) pending.push_back('{mr, md});
    if (av && expAr) pending.push_back('{ar, ad});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, fwd_reg1, fwd_reg2);
  endtask

  // The head presented during the reset cycle still reaches the register file at that edge.
  task automatic doReset();
    mem_valid = 1'b0; alu_valid = 1'b0; reset = 1'b1;
    #1;
    if (regWrite === 1'b1) obsRf[writeReg] = writeData;
    @(posedge clk);
    if (pending.size() != 0) modelRf[pending[0].r] = pending[0].d;
    pending.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < 16; r++) begin
      modelRf[r] = '0;
      obsRf[r]   = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkEq("rst_count", 32'(count), 0);
    checkEq("rst_regWrite", 32'(regWrite), 0);
    @(negedge clk);

    // Single ALU push into an empty queue.
    step(0, '0, '0, 1, 4'd3, 32'h1234, '0, '0);
    checkEq("t1_count", 32'(count), 1);
    checkEq("t1_regWrite", 32'(regWrite), 1);
    checkEq("t1_writeReg", 32'(writeReg), 3);
    checkEq("t1_writeData", writeData, 32'h1234);
    idle(1);
    checkEq("t1_drained", 32'(count), 0);
    checkEq("t1_r3", obsRf[3], 32'h1234);

    // Same-cycle pushes to one register: mem drains first, ALU value survives.
    step(1, 4'd5, 32'hAAAA, 1, 4'd5, 32'hBBBB, '0, '0);
    checkEq("t2_first", writeData, 32'hAAAA);
    idle(1);
    checkEq("t2_second", writeData, 32'hBBBB);
    idle(1);
    checkEq("t2_r5", obsRf[5], 32'hBBBB);

    // Back-to-back dual pushes saturate the queue.
    for (int i = 0; i < 8; i++) begin
      step(1, 4'(i), 32'h100 + 32'(i), 1, 4'(i + 8), 32'h200 + 32'(i), '0, '0);
      if (i == 1) begin
        checkEq("t3_count3", 32'(count), 3);
        mem_valid = 1'b1;
        #1;
        checkEq("t3_mem_ready", 32'(mem_ready), 1);
        checkEq("t3_alu_ready", 32'(alu_ready), 0);
      end
    end
    idle(5);

    // Two pending writes to r7; lookup must return the younger.
    step(1, 4'd7, 32'h11, 1, 4'd7, 32'h22, '0, '0);
    fwd_reg1 = 4'd7; fwd_reg2 = 4'd9;
    #1;
    checkEq("t4_hit1", 32'(fwd_hit1), 32'(FWD_EN));
    checkEq("t4_data1", fwd_data1, FWD_EN ? 32'h22 : 32'h0);
    checkEq("t4_hit2", 32'(fwd_hit2), 0);
    checkEq("t4_data2", fwd_data2, 0);
    checkEq("t4_head", writeData, 32'h11);
    idle(3);
    checkEq("t4_r7", obsRf[7], 32'h22);

    // Reset with three entries queued discards them.
    step(1, 4'd7, 32'h31, 1, 4'd2, 32'h32, 4'd7, 4'd2);
    step(1, 4'd7, 32'h33, 1, 4'd4, 32'h34, 4'd7, 4'd2);
    checkEq("t5_count3", 32'(count), 3);
    doReset();
    #1;
    checkEq("t5_count", 32'(count), 0);
    checkEq("t5_regWrite", 32'(regWrite), 0);
    checkEq("t5_hit1", 32'(fwd_hit1), 0);
    checkEq("t5_hit2", 32'(fwd_hit2), 0);
    idle(3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) doReset();
      else step($urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), $urandom,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    idle(DEPTH + 1);

    for (int r = 0; r < 16; r++) checkEq($sformatf("rf%0d", r), obsRf[r], modelRf[r]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
